// File: rtl/booth_seq_divider.sv
// booth_seq_divider
//   Sequential radix-2 non-restoring divider, one quotient bit per cycle.
//   It uses the same valid/ready operand and result handshake as the
//   radix-4 Booth multiplier that sits beside it in the arithmetic unit.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high; discards any in-flight operation
//   in_valid   operands A, B valid
//   in_ready   block can accept operands (high only in IDLE)
//   A, B       dividend, divisor (N bits)
//   out_valid  Q, R, DZ valid; held until out_ready
//   out_ready  consumer accepts result
//   Q, R       quotient, remainder (registered)
//   DZ         divide-by-zero flag (registered)
//
// Optional feature
//   BOOTH_DIV_SIGNED_EN  defined: two's-complement operands, quotient truncates
//                        toward zero, remainder takes the dividend's sign.
//                        undefined: unsigned operands and results.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one non-restoring iteration per cycle, N cycles
// FIX   | final remainder restore and sign correction, results loaded
// DONE  | out_valid high, waiting for out_ready
module booth_seq_divider #(
  parameter int N = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [N:1] A,
  input  logic [N:1] B,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [N:1] Q,
  output logic [N:1] R,
  output logic       DZ
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nxt;

  logic [N:1]    d;
  logic [N:1]    qr;
  // Partial remainder carries one bit beyond N+1: with a full-width divisor
  // the shifted value 2P+bit spans [-2D, 2D), which would overflow N+1 bits.
  logic [N+2:1]  p;
  logic [CW-1:0] cnt;

  logic          accept;
  logic          b_zero;
  logic [N:1]    a_mag;
  logic [N:1]    b_mag;
  logic [N+2:1]  p_sh;
  logic [N+2:1]  d_ext;
  logic [N+2:1]  p_nxt;
  logic [N:1]    r_mag;
  logic [N:1]    q_fix;
  logic [N:1]    r_fix;

`ifdef BOOTH_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  assign accept = in_valid && in_ready;
  assign b_zero = (B == '0);

  always_comb begin
`ifdef BOOTH_DIV_SIGNED_EN
    a_mag = A[N] ? ({N{1'b0}} - A) : A;
    b_mag = B[N] ? ({N{1'b0}} - B) : B;
`else
    a_mag = A;
    b_mag = B;
`endif
  end

  // One iteration: shift {P,Qreg} left, then subtract or add D depending on
  // the sign of P before the shift.
  always_comb begin
    p_sh  = {p[N+1:1], qr[N]};
    d_ext = {2'b00, d};
    p_nxt = p[N+2] ? (p_sh + d_ext) : (p_sh - d_ext);
  end

  // A negative final P is restored by adding D back; the result lies in
  // [0, D), so the low N bits of the sum are exact.
  assign r_mag = p[N+2] ? (p[N:1] + d) : p[N:1];

  always_comb begin
`ifdef BOOTH_DIV_SIGNED_EN
    q_fix = neg_q ? ({N{1'b0}} - qr)    : qr;
    r_fix = neg_r ? ({N{1'b0}} - r_mag) : r_mag;
`else
    q_fix = qr;
    r_fix = r_mag;
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = b_zero ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d     <= '0;
      qr    <= '0;
      p     <= '0;
      cnt   <= '0;
      Q     <= '0;
      R     <= '0;
      DZ    <= 1'b0;
`ifdef BOOTH_DIV_SIGNED_EN
      neg_q <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (b_zero) begin
              Q  <= '1;
              R  <= A;
              DZ <= 1'b1;
            end else begin
              d   <= b_mag;
              qr  <= a_mag;
              p   <= '0;
              cnt <= CW'(N - 1);
`ifdef BOOTH_DIV_SIGNED_EN
              neg_q <= A[N] ^ B[N];
              neg_r <= A[N];
`endif
            end
          end
        end
        CALC: begin
          p  <= p_nxt;
          qr <= {qr[N-1:1], ~p_nxt[N+2]};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          Q  <= q_fix;
          R  <= r_fix;
          DZ <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_divider.sv
module tb_booth_seq_divider;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N:1]   A;
  logic [N:1]   B;
  logic         out_valid;
  logic         out_ready;
  logic [N:1]   Q;
  logic [N:1]   R;
  logic         DZ;

  booth_seq_divider #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Q         (Q),
    .R         (R),
    .DZ        (DZ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];

  int n_vec    = 0;
  int n_err    = 0;
  int n_issued = 0;
  int n_done   = 0;
  int cyc      = 0;
  int rise_cyc = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: records when out_valid rises, compares on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("Q", Q, e.q);
        chk("R", R, e.r);
        chk("DZ", {31'd0, DZ}, {31'd0, e.dz});
        chk("latency", 32'(rise_cyc - e.acc + 1), 32'(e.lat));
      end
      n_done++;
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edz);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.q   = eq;
    e.r   = er;
    e.dz  = edz;
    e.lat = (b == 32'd0) ? 1 : N + 2;
    e.acc = cyc;
    sb.push_back(e);
    n_issued++;
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done();
    int k = 0;
    while (n_done < n_issued && k < 200) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (k >= 200) chk("result_timeout", 32'(n_done), 32'(n_issued));
  endtask

  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input logic edz);
    issue(a, b, eq, er, edz);
    wait_done();
  endtask

  initial begin
    int k;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_Q", Q, 32'd0);
    chk("rst_R", R, 32'd0);
    chk("rst_DZ", {31'd0, DZ}, 32'd0);

    op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0);
    op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1);
    op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0);
`ifdef BOOTH_DIV_SIGNED_EN
    op(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    op(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    op(32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    op(32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
`else
    op(32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 1'b0);
    op(32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    op(32'hFFFFFF9C, 32'd7, 32'h24924916, 32'd2, 1'b0);
`endif

    // Back-to-back issue with out_ready held high
    issue(32'd77, 32'd8, 32'd9, 32'd5, 1'b0);
    issue(32'd64, 32'd4, 32'd16, 32'd0, 1'b0);
    wait_done();

    // Backpressure: results and in_ready must hold while out_ready is low
    out_ready = 1'b0;
    issue(32'd1000, 32'd7, 32'd142, 32'd6, 1'b0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) chk("bp_valid_timeout", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_Q", Q, 32'd142);
      chk("bp_R", R, 32'd6);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    wait_done();
    chk("bp_in_ready_after", {31'd0, in_ready}, 32'd1);

    // Asynchronous reset during the 5th CALC cycle discards the operation
    wait_ready();
    in_valid = 1'b1;
    A = 32'd1234;
    B = 32'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_Q", Q, 32'd0);
    chk("arst_R", R, 32'd0);
    chk("arst_DZ", {31'd0, DZ}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    op(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
